// File: rtl/e_sched_pkg.sv
// Shared types, constants and helpers for the e_sched round-robin scheduler.
package e_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int CNT_W = 16;

    // Tag/pointer width for n requesters; never narrower than one bit.
    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/e_sched_rr.sv
// Combinational masked round-robin picker: lowest requester at or above ptr_i,
// otherwise the lowest requester overall.
module e_sched_rr
    import e_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int TW = tag_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [TW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [TW-1:0] idx_o,
    output logic          any_o
);

    logic [TW-1:0] idx_hi;
    logic [TW-1:0] idx_lo;
    logic          any_hi;

    always_comb begin
        idx_hi  = '0;
        idx_lo  = '0;
        any_hi  = 1'b0;
        any_o   = 1'b0;
        grant_o = '0;
        // Descending scan so the last hit left standing is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_lo = TW'(i);
                any_o  = 1'b1;
                if (i >= int'(ptr_i)) begin
                    idx_hi = TW'(i);
                    any_hi = 1'b1;
                end
            end
        end
        idx_o = any_hi ? idx_hi : idx_lo;
        if (any_o) grant_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/e_sched.sv
// Round-robin scheduler sharing one LAT-deep `e` datapath among N_REQ requesters,
// with tag shadow pipeline for response routing. Optional counters: E_SCHED_STATS_EN.
module e_sched
    import e_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int LAT   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                dp_valid,
    output logic [DW-1:0]       dp_data,
    input  logic [DW-1:0]       dp_result,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_data,
    output logic                busy
`ifdef E_SCHED_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [N_REQ*CNT_W-1:0] grant_cnt
`endif
);

    localparam int TW = tag_w(N_REQ);
    localparam logic [LAT-1:0] LAST_STAGE = LAT'(1) << (LAT - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] ptr_q, ptr_d;
    logic          dp_valid_q;
    logic [DW-1:0] dp_data_q;
    logic [TW-1:0] dp_tag_q;
    logic [LAT-1:0] sh_vld_q;
    logic [TW-1:0]  sh_tag_q [LAT];

    logic [N_REQ-1:0] grant;
    logic [TW-1:0]    gidx;
    logic             gany;
    logic             hs;
    logic             drain_done;

    e_sched_rr #(.N(N_REQ), .TW(TW)) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (gany)
    );

    // Handshake: req_valid[i] & req_ready[i]; the picker only grants valid requesters.
    assign req_ready = (state_q == RUN) ? grant : '0;
    assign hs        = (state_q == RUN) && gany;

    // Nothing remains in flight once the word in the final stage leaves this cycle.
    assign drain_done = !dp_valid_q && ((sh_vld_q & ~LAST_STAGE) == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en)              state_d = RUN;
                else if (drain_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (hs) ptr_d = (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            dp_valid_q <= 1'b0;
            dp_data_q  <= '0;
            dp_tag_q   <= '0;
            sh_vld_q   <= '0;
            for (int i = 0; i < LAT; i++) sh_tag_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            dp_valid_q <= hs;
            if (hs) begin
                dp_data_q <= req_data[int'(gidx)*DW +: DW];
                dp_tag_q  <= gidx;
            end
            sh_vld_q[0] <= dp_valid_q;
            sh_tag_q[0] <= dp_tag_q;
            for (int i = 1; i < LAT; i++) begin
                sh_vld_q[i] <= sh_vld_q[i-1];
                sh_tag_q[i] <= sh_tag_q[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (sh_vld_q[LAT-1]) begin
            rsp_valid[sh_tag_q[LAT-1]] = 1'b1;
            rsp_data                   = dp_result;
        end
    end

    assign dp_valid = dp_valid_q;
    assign dp_data  = dp_data_q;
    assign busy     = (state_q != IDLE) | dp_valid_q | (|sh_vld_q);

`ifdef E_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (stats_clr)
                    cnt_q[i] <= '0;
                else if (hs && int'(gidx) == i && cnt_q[i] != '1)
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
        assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
`endif

endmodule

// File: doc/e_sched.md
Name: e_sched

Overview:
- Round-robin scheduler that shares one instance of the 8-bit `e` datapath (k -> l -> +0x10) between N_REQ requesters.
- Issues at most one request per cycle into the datapath.
- Carries a requester tag alongside each in-flight word through a LAT-deep shadow pipeline.
- Routes each result back to the requester that issued it.
- Supports a graceful stop (drain) controlled by an enable input.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DW, 8, data width of requests, datapath and responses
- LAT, 2, cycles from dp_valid/dp_data sampled to matching dp_result valid (k and l each register once)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  1 = grant requests; 0 = stop granting and drain
- req_valid  input  N_REQ  per-requester request valid
- req_data  input  N_REQ*DW  packed request data; requester i occupies bits [i*DW +: DW]
- req_ready  output  N_REQ  one-hot grant; handshake completes when req_valid[i] and req_ready[i] are both 1
- dp_valid  output  1  word presented to datapath this cycle
- dp_data  output  DW  datapath input
- dp_result  input  DW  datapath output; valid exactly LAT cycles after the matching dp_valid
- rsp_valid  output  N_REQ  one-hot response strobe, single cycle
- rsp_data  output  DW  response data, meaningful only when any rsp_valid bit is 1
- busy  output  1  1 while any word is in flight or state is not IDLE

Behaviour:
- Reset values: req_ready=0, dp_valid=0, dp_data=0, rsp_valid=0, rsp_data=0, busy=0, rr pointer=0, all shadow stages invalid, state=IDLE.
- States:
  - IDLE: en=1 -> RUN.
  - RUN: en=0 -> DRAIN.
  - DRAIN: shadow pipeline empty -> IDLE; en=1 -> RUN (drain abandoned, granting resumes next cycle).
- Grant: combinational, RUN only. Pick the first valid requester scanning from ptr upward, modulo N_REQ. req_ready is one-hot on that index, zero otherwise. req_ready must not depend on any req_valid other than the scan.
- No grant in IDLE or DRAIN, or when no requester is valid.
- Pointer update: on a completed handshake at index g, ptr <= (g+1) mod N_REQ. With no handshake, ptr holds.
- Issue: dp_valid and dp_data are registered. The cycle after handshake g: dp_valid=1, dp_data=req_data[g]. Otherwise dp_valid=0, dp_data holds its last value.
- Shadow pipeline: LAT stages of {valid, tag[$clog2(N_REQ)-1:0]}, advanced every cycle, loaded from the issue register.
- Response: when the final stage is valid, rsp_valid[tag]=1 and rsp_data=dp_result, both combinational from stage and dp_result. No backpressure on responses; requesters must accept.
- Latency: handshake in cycle t -> dp_valid at t+1 -> rsp_valid at t+1+LAT.
- Throughput: one request per cycle, sustained.
- busy = (state!=IDLE) | dp_valid | any shadow stage valid.
- Boundaries:
  - All requesters valid: strict rotation 0,1,2,3,0,...
  - A single requester held valid is granted every cycle.
  - ptr wraps N_REQ-1 -> 0.
  - en falling in the same cycle as a handshake: the handshake completes (grant evaluated on current state), then DRAIN.
  - Reset mid-flight discards all in-flight words; no rsp_valid after reset.

Optional Feature:
- Macro E_SCHED_STATS_EN.
- When defined:
  - Adds output grant_cnt, width N_REQ*16: per-requester 16-bit saturating handshake counters (stick at 0xFFFF).
  - Adds input stats_clr: synchronous clear of all counters; a clear takes priority over an increment in the same cycle.
  - Counters reset to 0.
- When undefined: neither port exists and no counter logic is built.

Decomposition:
- Package e_sched_pkg:
  - state_t enum {IDLE, RUN, DRAIN}
  - CNT_W=16
  - function tag_w(n) returning $clog2(n), minimum 1
- Sub-module e_sched_rr: combinational masked round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, encoded index, any.
- e_sched owns the FSM, pointer register, issue register and shadow pipeline.

Test Plan:
- Reset, en=1, req_valid=4'b1111, req_data={0x04,0x03,0x02,0x01} (requester 3 first) -> grants 0,1,2,3,0 on consecutive cycles. rsp_valid[0] with rsp_data=0x11 at t+3 (LAT=2); then responses 0x12, 0x13, 0x14 on requesters 1, 2, 3 in following cycles.
- Only requester 2 valid with data 0xF5 for 3 cycles -> req_ready=4'b0100 every cycle; three rsp_valid[2] pulses carrying 0x05 (8-bit wrap of 0xF5+0x10).
- en dropped after 2 grants with 3 requesters still valid -> no further req_ready. busy stays 1 until the 2nd response, then 0 the next cycle with state IDLE.
- en dropped then raised one cycle later during DRAIN -> granting resumes at the saved ptr, with no lost or duplicated responses.
- rst_n asserted with 2 words in flight -> all outputs 0 immediately; no rsp_valid in the following LAT+2 cycles.
- E_SCHED_STATS_EN: 70000 cycles of requester 1 alone -> grant_cnt[1]=0xFFFF, others 0. Assert stats_clr -> all counters 0 next cycle.
